// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size encodings, FSM states and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_ERR,
    S_DONE
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath: load extract/extend and store merge.
// Purely combinational, little-endian lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16]
                          : i_word[15:0];
  end

  always_comb begin
    o_load_data   = i_word;
    o_merged_word = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load_data = {{24{!i_unsigned && w_byte[7]}},
                       w_byte};
        o_merged_word[{i_addr_lo, 3'b000} +: 8] =
          i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load_data = {{16{!i_unsigned && w_half[15]}},
                       w_half};
        o_merged_word[{i_addr_lo[1], 4'b0000} +: 16] =
          i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores,
// read-modify-write for sub-word stores, misalign trapping.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_store,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CW =
    (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(READ_LATENCY - 1);

  state_t        r_state;
  logic          r_store;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [1:0]    r_addr_lo;
  logic [15:0]   r_wdata;
  logic [CW-1:0] r_cnt;

  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign req_ready = reset && (r_state == S_IDLE);

  lsu_lane_align u_align (
    .i_word        (mem_read_data),
    .i_addr_lo     (r_addr_lo),
    .i_size        (r_size),
    .i_unsigned    (r_unsigned),
    .i_wdata       (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_store        <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_addr_lo      <= 2'b00;
      r_wdata        <= '0;
      r_cnt          <= '0;
      mem_load       <= 1'b0;
      mem_store      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      unique case (r_state)
        S_IDLE: if (req_valid) begin
          r_store    <= req_store;
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_addr_lo  <= req_addr[1:0];
          r_wdata    <= req_wdata[15:0];
          r_cnt      <= '0;
          if (misaligned(req_size, req_addr[1:0])) begin
            r_state <= S_ERR;
          end else begin
            mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_store && req_size == SZ_WORD) begin
              mem_write_data <= req_wdata;
              mem_store      <= 1'b1;
              r_state        <= S_WR;
            end else begin
              mem_load <= 1'b1;
              r_state  <= S_RD;
            end
          end
        end
        S_RD: r_state <= S_WAIT;
        S_WAIT: begin
          // Read word is only trusted on the final WAIT edge
          if (r_cnt == LAST) begin
            if (r_store) begin
              mem_write_data <= w_merged;
              mem_store      <= 1'b1;
              r_state        <= S_WR;
            end else begin
              resp_rdata <= w_load_data;
              resp_valid <= 1'b1;
              r_state    <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WR: begin
          resp_valid <= 1'b1;
          r_state    <= S_DONE;
        end
        S_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit.
// Two instances: READ_LATENCY 1 and 3, each with a memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_store, mem_load;
  logic [31:0] resp_rdata, mem_address, mem_write_data;
  logic [31:0] mem_read_data;

  logic        req_valid3, req_ready3, req_store3, req_unsigned3;
  logic [1:0]  req_size3;
  logic [31:0] req_addr3, req_wdata3;
  logic        resp_valid3, resp_err3, mem_store3, mem_load3;
  logic [31:0] resp_rdata3, mem_address3, mem_write_data3;
  logic [31:0] mem_read_data3;

  load_store_unit #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_store(mem_store), .mem_load(mem_load),
    .mem_read_data(mem_read_data)
  );

  load_store_unit #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_store(req_store3), .req_size(req_size3),
    .req_unsigned(req_unsigned3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .resp_valid(resp_valid3),
    .resp_err(resp_err3), .resp_rdata(resp_rdata3),
    .mem_address(mem_address3),
    .mem_write_data(mem_write_data3),
    .mem_store(mem_store3), .mem_load(mem_load3),
    .mem_read_data(mem_read_data3)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
  endfunction

  // Word memories, refilled while reset is low
  logic [31:0] mem [64];
  logic [31:0] mem3 [64];
  logic [31:0] rd1, junk, p0, p1, p2;
  logic        v0, v1, v2;

  always @(posedge clk) begin
    junk <= $urandom;
    rd1  <= mem_load ? mem[mem_address[7:2]] : $urandom;
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_store) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = rd1;

  always @(posedge clk) begin
    p0 <= mem3[mem_address3[7:2]];
    v0 <= mem_load3;
    p1 <= p0; v1 <= v0;
    p2 <= p1; v2 <= v1;
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem3[i] <= init_word(i);
    end else if (mem_store3) begin
      mem3[mem_address3[7:2]] <= mem_write_data3;
    end
  end
  assign mem_read_data3 = v2 ? p2 : junk;

  int c_ld = 0, c_st = 0, c_rv = 0, c_both = 0;
  int c_ld3 = 0, c_acc3 = 0;
  logic [31:0] last_sa = 0, last_sd = 0;

  always @(posedge clk) begin
    if (mem_load) c_ld <= c_ld + 1;
    if (mem_store) begin
      c_st    <= c_st + 1;
      last_sa <= mem_address;
      last_sd <= mem_write_data;
    end
    if (resp_valid) c_rv <= c_rv + 1;
    if (mem_load && mem_store) c_both <= c_both + 1;
    if (mem_load3 || mem_store3) c_ld3 <= c_ld3 + 1;
    if (req_valid3 && req_ready3) c_acc3 <= c_acc3 + 1;
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [64];

  function automatic logic misal(int sz, int a);
    return sz == 3 || (sz == 1 && a % 2 != 0) ||
           (sz == 2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(
    logic [31:0] w, int a, int sz, logic un);
    logic [31:0] v;
    int sh;
    sh = 8 * (a % 4);
    if (sz == 2) return w;
    if (sz == 0) begin
      v = (w >> sh) & 32'hFF;
      if (!un && v >= 128) v = v - 32'd256;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (!un && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(
    logic [31:0] w, int a, int sz, logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2) return d;
    sh = 8 * (a % 4);
    mask = (sz == 0 ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic issue(
    input logic st, input logic [1:0] sz, input logic un,
    input logic [31:0] a, input logic [31:0] wd,
    output logic [31:0] rd, output logic er, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    req_valid = 1'b1; req_store = st; req_size = sz;
    req_unsigned = un; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_store = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic test_reset();
    int s;
    reset = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_WORD;
    req_addr = 32'h4; req_unsigned = 1'b0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_load, mem_store, resp_valid, resp_err, req_ready}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000",
        {mem_load, mem_store, resp_valid, resp_err, req_ready});
    end
    n_checks++;
    if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0",
        resp_rdata, mem_address, mem_write_data);
    end
    s = c_ld;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (c_ld - s !== 0) begin
      n_fail++;
      $display("FAIL reset_ignored_req: got %0d loads want 0",
        c_ld - s);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic er;
    int lat, sl, ss;
    sl = c_ld; ss = c_st;
    issue(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEADBEEF, rd, er, lat);
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_resp: got lat %0d err %b rd %h want 2 0 0",
        lat, er, rd);
    end
    n_checks++;
    if (c_st - ss !== 1 || c_ld - sl !== 0) begin
      n_fail++;
      $display("FAIL sw_strobes: got st %0d ld %0d want 1 0",
        c_st - ss, c_ld - sl);
    end
    n_checks++;
    if (last_sa !== 32'h4 || last_sd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_bus: got %h/%h want 4/deadbeef",
        last_sa, last_sd);
    end
    issue(1'b0, SZ_WORD, 1'b1, 32'h4, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("FAIL lw: got rd %h err %b lat %0d want deadbeef 0 3",
        rd, er, lat);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    logic er;
    int lat, sl, ss;
    issue(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h12345678, rd, er, lat);
    issue(1'b1, SZ_WORD, 1'b0, 32'hC, 32'h12345678, rd, er, lat);
    sl = c_ld; ss = c_st;
    issue(1'b1, SZ_BYTE, 1'b0, 32'hA, 32'hFFFFFFAB, rd, er, lat);
    n_checks++;
    if (mem[2] !== 32'h12AB5678 || lat !== 4 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sb_rmw: got mem %h lat %0d rd %h want 12ab5678 4 0",
        mem[2], lat, rd);
    end
    n_checks++;
    if (c_ld - sl !== 1 || c_st - ss !== 1) begin
      n_fail++;
      $display("FAIL sb_strobes: got ld %0d st %0d want 1 1",
        c_ld - sl, c_st - ss);
    end
    issue(1'b0, SZ_BYTE, 1'b0, 32'hA, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFFAB) begin
      n_fail++;
      $display("FAIL lb: got %h want ffffffab", rd);
    end
    issue(1'b0, SZ_BYTE, 1'b1, 32'hA, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h000000AB) begin
      n_fail++;
      $display("FAIL lbu: got %h want 000000ab", rd);
    end
    issue(1'b1, SZ_HALF, 1'b0, 32'hE, 32'h55558001, rd, er, lat);
    n_checks++;
    if (mem[3] !== 32'h80015678) begin
      n_fail++;
      $display("FAIL sh_rmw: got %h want 80015678", mem[3]);
    end
    issue(1'b0, SZ_HALF, 1'b0, 32'hE, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFF8001) begin
      n_fail++;
      $display("FAIL lh: got %h want ffff8001", rd);
    end
    issue(1'b0, SZ_HALF, 1'b1, 32'hE, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00008001) begin
      n_fail++;
      $display("FAIL lhu: got %h want 00008001", rd);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, m0, m1;
    logic er;
    int lat, sl, ss;
    logic        t_st [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz [3] = '{SZ_HALF, SZ_WORD, 2'b11};
    logic [31:0] t_a  [3] = '{32'h5, 32'h6, 32'h0};
    m0 = mem[0]; m1 = mem[1];
    for (int k = 0; k < 3; k++) begin
      sl = c_ld; ss = c_st;
      issue(t_st[k], t_sz[k], 1'b0, t_a[k], 32'hCAFEF00D,
            rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
        n_fail++;
        $display("FAIL misalign_%0d: got err %b rd %h lat %0d want 1 0 2",
          k, er, rd, lat);
      end
      n_checks++;
      if (c_ld - sl !== 0 || c_st - ss !== 0) begin
        n_fail++;
        $display("FAIL misalign_mem_%0d: got ld %0d st %0d want 0 0",
          k, c_ld - sl, c_st - ss);
      end
    end
    n_checks++;
    if (mem[0] !== m0 || mem[1] !== m1) begin
      n_fail++;
      $display("FAIL misalign_unchanged: got %h %h want %h %h",
        mem[0], mem[1], m0, m1);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd;
    logic er, un, st, bad;
    int lat, a, sz, exp_lat, sb;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    sb = c_both;
    for (int n = 0; n < 120; n++) begin
      a  = $urandom_range(0, 255);
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        a = (sz == 2) ? a & ~3 : (sz == 1) ? a & ~1 : a;
      st = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      wd = $urandom;
      bad = misal(sz, a);
      exp_rd = 32'h0;
      if (bad) exp_lat = 2;
      else if (st && sz == 2) exp_lat = 2;
      else if (st) exp_lat = 1 + 3;
      else exp_lat = 1 + 2;
      if (!bad && !st)
        exp_rd = ref_load(ref_mem[a / 4], a, sz, un);
      if (!bad && st)
        ref_mem[a / 4] = ref_merge(ref_mem[a / 4], a, sz, wd);
      issue(st, 2'(sz), un, 32'(a), wd, rd, er, lat);
      n_checks++;
      if (rd !== exp_rd || er !== bad || lat !== exp_lat) begin
        n_fail++;
        $display("FAIL rand_%0d st%b sz%0d a%h: got %h/%b/%0d want %h/%b/%0d",
          n, st, sz, a, rd, er, lat, exp_rd, bad, exp_lat);
      end
      n_checks++;
      if (mem[a / 4] !== ref_mem[a / 4]) begin
        n_fail++;
        $display("FAIL rand_mem_%0d a%h: got %h want %h",
          n, a, mem[a / 4], ref_mem[a / 4]);
      end
    end
    n_checks++;
    if (c_both - sb !== 0) begin
      n_fail++;
      $display("FAIL ld_st_overlap: got %0d want 0", c_both - sb);
    end
  endtask

  task automatic test_reset_abort();
    int sl, ss, sr, w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    sl = c_ld; ss = c_st; sr = c_rv;
    req_valid = 1'b1; req_store = 1'b1; req_size = SZ_BYTE;
    req_unsigned = 1'b0; req_addr = 32'h21; req_wdata = 32'h5C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_load, mem_store, resp_valid, resp_err, req_ready,
         resp_rdata, mem_address, mem_write_data} !== 101'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b%b%b%b%b %h %h %h want 0",
        mem_load, mem_store, resp_valid, resp_err, req_ready,
        resp_rdata, mem_address, mem_write_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: got %b want 1", req_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (c_ld - sl !== 1 || c_st - ss !== 0 || c_rv - sr !== 0) begin
      n_fail++;
      $display("FAIL abort_strobes: got ld %0d st %0d rv %0d want 1 0 0",
        c_ld - sl, c_st - ss, c_rv - sr);
    end
    n_checks++;
    if (mem[8] !== init_word(8)) begin
      n_fail++;
      $display("FAIL abort_mem: got %h want %h", mem[8], init_word(8));
    end
  endtask

  task automatic test_latency3();
    int lat, sa, sm;
    sa = c_acc3; sm = c_ld3;
    req_valid3 = 1'b1; req_store3 = 1'b0; req_size3 = SZ_WORD;
    req_unsigned3 = 1'b0; req_addr3 = 32'h4; req_wdata3 = 0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_load3 !== 1'b1 || mem_address3 !== 32'h4) begin
      n_fail++;
      $display("FAIL rl3_load: got %b @%h want 1 @4",
        mem_load3, mem_address3);
    end
    lat = 1;
    while (!resp_valid3 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 5 || resp_rdata3 !== init_word(1) ||
        resp_err3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rl3_resp: got lat %0d rd %h err %b want 5 %h 0",
        lat, resp_rdata3, resp_err3, init_word(1));
    end
    n_checks++;
    if (c_ld3 - sm !== 1 || c_acc3 - sa !== 1 ||
        req_ready3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rl3_busy: got strobes %0d acc %0d rdy %b want 1 1 0",
        c_ld3 - sm, c_acc3 - sa, req_ready3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL rl3_idle_ready: got %b want 1", req_ready3);
    end
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    n_checks++;
    if (c_acc3 - sa !== 2) begin
      n_fail++;
      $display("FAIL rl3_second_accept: got %0d want 2", c_acc3 - sa);
    end
    lat = 1;
    while (!resp_valid3 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 5 || resp_rdata3 !== init_word(1)) begin
      n_fail++;
      $display("FAIL rl3_second_resp: got lat %0d rd %h want 5 %h",
        lat, resp_rdata3, init_word(1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_valid3 = 1'b0; req_store3 = 1'b0; req_size3 = 2'b00;
    req_unsigned3 = 1'b0; req_addr3 = 0; req_wdata3 = 0;
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_random();
    test_reset_abort();
    test_latency3();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
